hex_display_scheduler: RTL and testbench

//   Owns the single SegmentDecoder instance and shares it across NUM_DIGITS HEX

---
 rtl/hex_display_scheduler_pkg.sv | 26 ++
 rtl/hex_display_scheduler_decoder.sv | 38 +++
 rtl/hex_display_scheduler.sv | 177 +++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : hex_disp_pkg
// Desc   : Shared state/source encodings and segment constants for the
//          HEX display scheduler.
// Rev    : 1.0
// ============================================================================
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        SRC_VAL = 1'b0,
        SRC_MSG = 1'b1
    } src_t;

    // Active-low segments: all ones is a dark digit.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/hex_display_scheduler_decoder.sv
`default_nettype none
// ============================================================================
// Module : hex_display_scheduler_decoder
// Desc   : Combinational hex nibble to active-low 7-segment (bit6=g..bit0=a).
// Rev    : 1.0
// ============================================================================
module hex_display_scheduler_decoder
    import hex_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module : hex_display_scheduler
// Desc   : Arbitrates value/message requesters and time-shares one segment
//          decoder across NUM_DIGITS held HEX digits, with blink gating.
// Rev    : 1.0
// ============================================================================
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      val_req,
    input  logic [4*NUM_DIGITS-1:0]   val_data,
    output logic                      val_ack,
    input  logic                      msg_req,
    input  logic [4*NUM_DIGITS-1:0]   msg_data,
    output logic                      msg_ack,
    input  logic                      blank_lz,
    input  logic                      blink_en,
    output logic                      busy,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam int c_blink_w = $clog2(BLINK_CYCLES + 1);

    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    src_t                   r_src;
    src_t                   w_src_nxt;
    logic [3:0]             r_shadow [NUM_DIGITS];
    logic [6:0]             r_hex    [NUM_DIGITS];
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_lz;
    logic [c_hold_w-1:0]    r_hold_cnt;
    logic [c_blink_w-1:0]   r_blink_cnt;
    logic                   r_blink_off;

    logic [4*NUM_DIGITS-1:0] w_load_data;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg;
    logic [6:0]              w_seg_wr;
    logic                    w_blank;

    // ------------------------------------------------------------------
    // Arbiter / sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= SRC_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        val_ack     = 1'b0;
        msg_ack     = 1'b0;
        busy        = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (msg_req) begin
                    w_state_nxt = LOAD;
                    w_src_nxt   = SRC_MSG;
                end else if (val_req) begin
                    w_state_nxt = LOAD;
                    w_src_nxt   = SRC_VAL;
                end
            end
            LOAD: begin
                val_ack     = (r_src == SRC_VAL);
                msg_ack     = (r_src == SRC_MSG);
                w_state_nxt = SCAN;
            end
            SCAN: begin
                if (r_idx == '0)
                    w_state_nxt = (r_src == SRC_MSG) ? HOLD : IDLE;
            end
            HOLD: begin
                // A fresh message preempts the lock; values wait it out.
                if (msg_req) begin
                    w_state_nxt = LOAD;
                    w_src_nxt   = SRC_MSG;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared decoder and scan datapath
    // ------------------------------------------------------------------
    assign w_load_data = (r_src == SRC_MSG) ? msg_data : val_data;
    assign w_nibble    = r_shadow[r_idx];

    hex_display_scheduler_decoder u_segment_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Leading-zero blanking applies only to values and never to digit 0.
    assign w_seg_wr = ((r_src == SRC_VAL) && r_lz && (w_nibble == 4'h0) && (r_idx != '0))
                    ? SEG_BLANK : w_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= 4'h0;
                r_hex[i]    <= SEG_BLANK;
            end
            r_idx      <= '0;
            r_lz       <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        r_shadow[i] <= w_load_data[i*4 +: 4];
                    r_idx <= c_idx_last;
                    r_lz  <= blank_lz;
                end
                SCAN: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (r_idx == c_idx_w'(i))
                            r_hex[i] <= w_seg_wr;
                    if (w_nibble != 4'h0)
                        r_lz <= 1'b0;
                    r_idx      <= r_idx - 1'b1;
                    r_hold_cnt <= '0;
                end
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Blink phase and output gating
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = blink_en & r_blink_off;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_out
        assign hex_out[g*7 +: 7] = r_hex[g] | {7{w_blank}};
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_hex_display_scheduler
// Desc   : Self-checking bench with a transaction-level display model.
// Rev    : 1.0
// ============================================================================
module tb_hex_display_scheduler;

    localparam int N = 4;
    localparam int H = 8;
    localparam int B = 4;
    localparam logic [27:0] ALL_DARK = 28'hFFFFFFF;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        val_req  = 1'b0;
    logic        msg_req  = 1'b0;
    logic [15:0] val_data = '0;
    logic [15:0] msg_data = '0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic        val_ack;
    logic        msg_ack;
    logic        busy;
    logic [27:0] hex_out;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          bcnt     = 0;
    int          dark_seen;
    logic [27:0] m_disp   = ALL_DARK;

    hex_display_scheduler #(
        .NUM_DIGITS   (N),
        .HOLD_CYCLES  (H),
        .BLINK_CYCLES (B)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .val_req  (val_req),
        .val_data (val_data),
        .val_ack  (val_ack),
        .msg_req  (msg_req),
        .msg_data (msg_data),
        .msg_ack  (msg_ack),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release; the blink phase derives from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else        bcnt <= bcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [27:0] expect_disp(input logic [15:0] d, input bit is_val, input bit lz);
        logic [27:0] r = '0;
        int top = 0;
        for (int k = 0; k < N; k++)
            if (d[k*4 +: 4] != 4'h0) top = k;
        for (int k = 0; k < N; k++)
            r[k*7 +: 7] = (is_val && lz && k > top) ? 7'h7F : seg_of(d[k*4 +: 4]);
        return r;
    endfunction

    function automatic logic [27:0] shown();
        bit off = ((bcnt / B) % 2) == 1;
        return m_disp | ((blink_en && off) ? ALL_DARK : 28'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        check(tag, hex_out, shown());
    endtask

    // Called from IDLE: raise requests, expect the ack on the next cycle.
    task automatic request(input bit v, input bit m, input logic [15:0] vd,
                           input logic [15:0] md, input bit lz);
        val_data = vd;
        msg_data = md;
        blank_lz = lz;
        val_req  = v;
        msg_req  = m;
        tick();
        check("ack_msg", msg_ack, m);
        check("ack_val", val_ack, v & ~m);
    endtask

    // Called at the ack cycle T; returns at T+N+1 with every digit updated.
    task automatic scan(input bit is_msg, input logic [15:0] d, input bit lz);
        logic [27:0] target = expect_disp(d, !is_msg, lz);
        if (is_msg) msg_req = 1'b0;
        else        val_req = 1'b0;
        tick();
        check("scan_busy", busy, 1'b1);
        check_out("scan_first");
        for (int j = 1; j <= N; j++) begin
            tick();
            m_disp[(N-j)*7 +: 7] = target[(N-j)*7 +: 7];
            check_out("scan_digit");
            check("scan_no_ack", {msg_ack, val_ack}, 2'b00);
        end
    endtask

    task automatic hold_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            check("hold_busy", busy, 1'b1);
            check("hold_no_ack", {msg_ack, val_ack}, 2'b00);
            check_out("hold_disp");
            tick();
        end
    endtask

    initial begin
        logic [15:0] vd;
        logic [15:0] md;
        int          kind;
        bit          lz;

        #1 rst_n = 1'b0;
        #11;
        check("rst_hex", hex_out, ALL_DARK);
        check("rst_acks", {msg_ack, val_ack}, 2'b00);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Value with leading-zero blanking
        request(1, 0, 16'h0042, 16'h0, 1);
        scan(0, 16'h0042, 1);
        check("val42_busy", busy, 1'b0);
        check("val42_hex", hex_out, {7'h7F, 7'h7F, 7'h19, 7'h24});

        request(1, 0, 16'h0000, 16'h0, 1);
        scan(0, 16'h0000, 1);
        check("zero_lz_hex", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        request(1, 0, 16'h0000, 16'h0, 0);
        scan(0, 16'h0000, 0);
        check("zero_nolz_hex", hex_out, {7'h40, 7'h40, 7'h40, 7'h40});

        // Simultaneous requests: message first, value after the full hold
        request(1, 1, 16'h1230, 16'hE0F1, 1);
        scan(1, 16'hE0F1, 1);
        check("msg_hex", hex_out, {7'h06, 7'h40, 7'h0E, 7'h79});
        hold_cycles(H);
        check("hold_end_busy", busy, 1'b0);
        tick();
        check("val_after_hold", val_ack, 1'b1);
        scan(0, 16'h1230, 1);
        check("val_after_busy", busy, 1'b0);

        // Preemption in HOLD restarts the full hold window
        request(0, 1, 16'h0, 16'hE0F1, 0);
        scan(1, 16'hE0F1, 0);
        hold_cycles(3);
        msg_data = 16'h1234;
        msg_req  = 1'b1;
        tick();
        check("preempt_ack", msg_ack, 1'b1);
        scan(1, 16'h1234, 0);
        hold_cycles(H);
        check("preempt_done", busy, 1'b0);

        // Value withdrawn while the message hold runs
        request(0, 1, 16'h0, 16'hABCD, 0);
        scan(1, 16'hABCD, 0);
        val_data = 16'h0007;
        val_req  = 1'b1;
        hold_cycles(2);
        val_req  = 1'b0;
        hold_cycles(H - 2);
        for (int j = 0; j < 3; j++) begin
            check("withdrawn", {busy, msg_ack, val_ack}, 3'b000);
            tick();
        end

        // Blink gating over shown content
        blink_en  = 1'b1;
        dark_seen = 0;
        for (int j = 0; j < 4 * B; j++) begin
            tick();
            check_out("blink");
            if (hex_out == ALL_DARK) dark_seen++;
        end
        check("blink_dark_cycles", dark_seen, 2 * B);
        blink_en = 1'b0;
        tick();
        check("blink_restore", hex_out, m_disp);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            vd = 16'($urandom);
            md = 16'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) vd[k*4 +: 4] = 4'h0;
                if ($urandom_range(0, 2) == 0) md[k*4 +: 4] = 4'h0;
            end
            kind     = $urandom_range(0, 2);
            lz       = 1'($urandom_range(0, 1));
            blink_en = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                request(1, 0, vd, md, lz);
                scan(0, vd, lz);
                check("rnd_val_done", busy, 1'b0);
            end else begin
                request(kind == 2, 1, vd, md, lz);
                scan(1, md, lz);
                hold_cycles(H);
                check("rnd_hold_done", busy, 1'b0);
                if (kind == 2) begin
                    tick();
                    check("rnd_val_ack", val_ack, 1'b1);
                    scan(0, vd, lz);
                    check("rnd_val_done2", busy, 1'b0);
                end
            end
        end
        blink_en = 1'b0;

        // Asynchronous reset in the middle of a scan
        request(1, 0, 16'h5678, 16'h0, 0);
        val_req = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        m_disp = ALL_DARK;
        check("midrst_hex", hex_out, ALL_DARK);
        check("midrst_acks", {msg_ack, val_ack}, 2'b00);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("postrst_idle", {busy, msg_ack, val_ack}, 3'b000);
            check_out("postrst_hex");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
